// File: rtl/l0_seq_ctrl.sv
// l0_seq_ctrl: sequencer for the L0 row-FIFO input buffer feeding the systolic array.
// A start command loads num_vec vectors from SRAM into L0 (one per cycle), then drains
// L0 into the array in the latched read mode. Load and drain never overlap.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           one-cycle command pulse, sampled only when idle
//   base_addr       first SRAM address (latched on accepted start)
//   num_vec         vectors to transfer, legal 1..DEPTH (latched on accepted start)
//   mode            1: all rows read per cycle, 0: one row per cycle (latched on start)
//   hold            array backpressure, pauses the drain
//   l0_full         L0 full status, flagged as an error if seen during a write
//   l0_ready        L0 status, informational only
//   sram_cen        SRAM chip enable, active low
//   sram_addr       SRAM read address
//   l0_wr, l0_rd    L0 write strobe / read request
//   l0_data_mode    L0 data_mode, equals the latched mode
//   busy, done, err status: busy outside idle, one-cycle done pulse, error flag
module l0_seq_ctrl #(
  parameter int unsigned ROW   = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 11,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] num_vec,
  input  logic          mode,
  input  logic          hold,
  input  logic          l0_full,
  input  logic          l0_ready,
  output logic          sram_cen,
  output logic [AW-1:0] sram_addr,
  output logic          l0_wr,
  output logic          l0_rd,
  output logic          l0_data_mode,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned RW = (ROW > 1) ? $clog2(ROW) : 1;
  // Drain count reaches num_vec*ROW in one-row mode.
  localparam int unsigned TW = CW + RW;

  typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] num_q, num_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [TW-1:0] rd_cnt_q, rd_cnt_d;
  logic [RW-1:0] rot_q, rot_d;
  logic          sticky_q, sticky_d;
  logic          cen_q, cen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [TW-1:0] total;
  logic          stall;
  logic          bad_start;
  logic          unused_ready;

  assign unused_ready = l0_ready;

  assign total = mode_q ? TW'(num_q) : TW'(num_q) * TW'(ROW);
  // One-row mode may only pause at a rotation boundary: L0 restarts at row 0 when rd drops.
  assign stall = hold && (mode_q || (rot_q == '0));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    mode_d    = mode_q;
    ld_cnt_d  = ld_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rot_d     = rot_q;
    sticky_d  = sticky_q;
    cen_d     = 1'b1;
    addr_d    = addr_q;
    wr_d      = !cen_q;  // SRAM read latency is one cycle
    rd_d      = 1'b0;
    busy_d    = (state_q != StIdle);
    done_d    = 1'b0;
    bad_start = 1'b0;

    if (wr_q && l0_full) sticky_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((num_vec != '0) && (32'(num_vec) <= DEPTH)) begin
            base_d   = base_addr;
            num_d    = num_vec;
            mode_d   = mode;
            ld_cnt_d = '0;
            rd_cnt_d = '0;
            rot_d    = '0;
            sticky_d = 1'b0;
            state_d  = StLoad;
          end else begin
            bad_start = 1'b1;
          end
        end
      end
      StLoad: begin
        cen_d    = 1'b0;
        addr_d   = base_q + AW'(ld_cnt_q);
        ld_cnt_d = ld_cnt_q + CW'(1);
        if (ld_cnt_q == num_q - CW'(1)) state_d = StFlush;
      end
      StFlush: begin
        state_d = StDrain;
      end
      StDrain: begin
        if (!stall) begin
          rd_d     = 1'b1;
          rd_cnt_d = rd_cnt_q + TW'(1);
          rot_d    = (rot_q == RW'(ROW - 1)) ? '0 : rot_q + RW'(1);
          if (rd_cnt_d == total) state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    err_d = sticky_d | bad_start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      num_q    <= '0;
      mode_q   <= 1'b0;
      ld_cnt_q <= '0;
      rd_cnt_q <= '0;
      rot_q    <= '0;
      sticky_q <= 1'b0;
      cen_q    <= 1'b1;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      num_q    <= num_d;
      mode_q   <= mode_d;
      ld_cnt_q <= ld_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      rot_q    <= rot_d;
      sticky_q <= sticky_d;
      cen_q    <= cen_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sram_cen     = cen_q;
  assign sram_addr    = addr_q;
  assign l0_wr        = wr_q;
  assign l0_rd        = rd_q;
  assign l0_data_mode = mode_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_l0_seq_ctrl.sv
// Bench for l0_seq_ctrl: directed commands push expected output events into a scoreboard,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_l0_seq_ctrl;
  localparam int AW = 11;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_vec = '0;
  logic          mode = 1'b0;
  logic          hold = 1'b0;
  logic          l0_full = 1'b0;
  logic          l0_ready = 1'b1;
  logic          sram_cen, l0_wr, l0_rd, l0_data_mode, busy, done, err;
  logic [AW-1:0] sram_addr;

  l0_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_vec     (num_vec),
    .mode        (mode),
    .hold        (hold),
    .l0_full     (l0_full),
    .l0_ready    (l0_ready),
    .sram_cen    (sram_cen),
    .sram_addr   (sram_addr),
    .l0_wr       (l0_wr),
    .l0_rd       (l0_rd),
    .l0_data_mode(l0_data_mode),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          cen;
    logic [AW-1:0] addr;
    logic          wr, rd, dn, er, bs, dm;
  } rec_t;

  rec_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic exp_err = 1'b0;
  logic last_mode = 1'b0;
  logic mon_en = 1'b0;
  logic err_prev = 1'b0;

  task automatic push(input int c, input logic cen, input logic [AW-1:0] a, input logic wr,
                      input logic rd, input logic dn, input logic er, input logic bs,
                      input logic dm);
    rec_t r;
    r = '{c, cen, a, wr, rd, dn, er, bs, dm};
    sbq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every cycle with activity (or an err edge) must match the next expected event.
  always @(negedge clk) begin
    rec_t e;
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL sb_missing cyc=%0d: got no event, expected one", e.cyc);
      end
      if (sram_cen === 1'b0 || l0_wr === 1'b1 || l0_rd === 1'b1 || done === 1'b1 ||
          err !== err_prev) begin
        total++;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          e = sbq.pop_front();
          if (sram_cen !== e.cen || (!e.cen && sram_addr !== e.addr) || l0_wr !== e.wr ||
              l0_rd !== e.rd || done !== e.dn || err !== e.er || busy !== e.bs ||
              l0_data_mode !== e.dm) begin
            bad++;
            $display("FAIL sb_event cyc=%0d: got cen=%b addr=%h wr=%b rd=%b done=%b err=%b busy=%b dm=%b expected cen=%b addr=%h wr=%b rd=%b done=%b err=%b busy=%b dm=%b",
                     cyc, sram_cen, sram_addr, l0_wr, l0_rd, done, err, busy, l0_data_mode,
                     e.cen, e.addr, e.wr, e.rd, e.dn, e.er, e.bs, e.dm);
          end
        end else begin
          bad++;
          $display("FAIL sb_unexpected cyc=%0d: got cen=%b wr=%b rd=%b done=%b err=%b, expected no event",
                   cyc, sram_cen, l0_wr, l0_rd, done, err);
        end
      end
    end
    err_prev <= err;
  end

  // Edges are numbered from the start-sampling edge E0. hold_from..hold_to: edges where hold
  // is sampled high; stall_at/stall_len: edges with no read; full_edge: edge sampling l0_full;
  // err_at: first edge after which err is high; start_until: last edge start is held high;
  // abort_at: edge sampling reset (0 = none).
  task automatic run_cmd(input int md, input int base, input int n, input int hold_from,
                         input int hold_to, input int stall_at, input int stall_len,
                         input int full_edge, input int err_at, input int start_until,
                         input int abort_at);
    int e0, tt, cnt, done_k, last;
    logic pe, ee, rr, cen, wr, dn, bs;
    logic [AW-1:0] a;
    @(negedge clk);
    mode = md[0];
    base_addr = AW'(base);
    num_vec = CW'(n);
    start = 1'b1;
    e0 = cyc + 1;
    tt = (md != 0) ? n : n * 8;
    cnt = 0;
    done_k = -1;
    pe = exp_err;
    for (int k = 0; done_k < 0 || k <= done_k; k++) begin
      if (abort_at > 0 && k >= abort_at) break;
      rr = 1'b0;
      if (k >= n + 2 && cnt < tt && !(k >= stall_at && k < stall_at + stall_len)) begin
        rr = 1'b1;
        cnt++;
        if (cnt == tt) done_k = k + 1;
      end
      ee  = (err_at > 0 && k >= err_at);
      cen = !(k >= 1 && k <= n);
      wr  = (k >= 2 && k <= n + 1);
      dn  = (k == done_k) && !rr;
      bs  = (k >= 1) && (done_k < 0 || k <= done_k);
      a   = AW'(base + k - 1);
      if (!cen || wr || rr || dn || ee != pe) push(e0 + k, cen, a, wr, rr, dn, ee, bs, md[0]);
      pe = ee;
    end
    last = (abort_at > 0) ? abort_at : done_k + 2;
    for (int k = 0; k < last; k++) begin
      @(negedge clk);
      start   = (k + 1 <= start_until);
      hold    = (k + 1 >= hold_from && k + 1 <= hold_to);
      l0_full = (k + 1 == full_edge);
      if (abort_at > 0 && k + 1 == abort_at) reset = 1'b1;
    end
    start = 1'b0;
    if (abort_at > 0) begin
      @(negedge clk);
      chk("abort_reset_vals", {14'd0, sram_cen, sram_addr, l0_wr, l0_rd, l0_data_mode, busy,
                               done, err}, {14'd0, 1'b1, 11'd0, 6'd0});
      reset = 1'b0;
      exp_err = 1'b0;
      last_mode = 1'b0;
    end else begin
      chk("busy_after_done", {30'd0, busy, done}, 32'd0);
      exp_err = pe;
      last_mode = md[0];
    end
  endtask

  // Rejected start: err pulses for one cycle, nothing else moves.
  task automatic bad_start(input int n);
    int e0;
    @(negedge clk);
    num_vec = CW'(n);
    start = 1'b1;
    e0 = cyc + 1;
    push(e0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, last_mode);
    push(e0 + 1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_mode);
    @(negedge clk);
    start = 1'b0;
    chk("bad_start_idle", {30'd0, busy, sram_cen}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vals", {14'd0, sram_cen, sram_addr, l0_wr, l0_rd, l0_data_mode, busy, done, err},
        {14'd0, 1'b1, 11'd0, 6'd0});
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(1, 'h010, 4, 0, 0, 0, 0, 0, 0, 0, 0);    // all-rows mode
    run_cmd(0, 'h100, 2, 0, 0, 0, 0, 0, 0, 0, 0);    // one-row mode, 16 reads
    run_cmd(0, 'h200, 2, 7, 13, 12, 2, 0, 0, 0, 0);  // hold only honored at rd_cnt=8
    run_cmd(1, 'h300, 3, 7, 8, 7, 2, 0, 0, 0, 0);    // hold honored immediately in mode 1
    bad_start(0);
    bad_start(17);
    run_cmd(1, 'h7FE, 3, 0, 0, 0, 0, 0, 0, 0, 0);    // address wraps
    run_cmd(1, 'h020, 3, 0, 0, 0, 0, 4, 4, 0, 0);    // l0_full on second write, sticky err
    run_cmd(1, 'h030, 1, 0, 0, 0, 0, 0, 0, 0, 0);    // accepted start clears err
    run_cmd(1, 'h040, 8, 0, 0, 0, 0, 0, 0, 8, 13);   // start held while busy, reset mid-drain
    run_cmd(0, 'h050, 1, 0, 0, 0, 0, 0, 0, 0, 0);    // recovers after reset

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
